// File: rtl/sdcard_shifter.sv
// SPI-master byte shifter shared by the AVR and Z80 SD ports; owner follows the AVR lock bit.
// Optional SDSHIFT_SYNC_EN: 2-flop sddi synchronizer with late sample point (HALF_PER >= 3).
//
// state | meaning
// IDLE  | waiting for the owner's start strobe; lock_ack tracks avr_lock
// SHIFT | clocking one byte out on sddo and in from sddi; lock_ack frozen
module sdcard_shifter #(
  parameter int HALF_PER = 2
) (
  input  logic       fclk,
  input  logic       rst_n,
  input  logic       avr_lock,
  input  logic       avr_cs_n,
  input  logic       avr_start,
  input  logic [7:0] avr_datain,
  input  logic       z80_cs_n,
  input  logic       z80_start,
  input  logic [7:0] z80_datain,
  output logic       lock_ack,
  output logic       busy,
  output logic [7:0] dataout,
  output logic       sdclk,
  output logic       sddo,
  input  logic       sddi,
  output logic       sdcs_n
);

  typedef enum logic {IDLE, SHIFT} state_e;

  localparam logic [3:0] HALF_TC = 4'(HALF_PER - 1);

  state_e     state_q, state_d;
  logic       lock_ack_q, lock_ack_d;
  logic       busy_q, busy_d;
  logic       sdclk_q, sdclk_d;
  logic       sddo_q, sddo_d;
  logic [7:0] dataout_q, dataout_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] in_q, in_d;
  logic [3:0] half_q, half_d;
  logic [2:0] bit_q, bit_d;

  logic       half_tc;
  logic       sample_now;
  logic       sddi_smp;
  logic       start_acc;
  logic [7:0] tx_byte;

  assign half_tc = (half_q == HALF_TC);

`ifdef SDSHIFT_SYNC_EN
  logic [1:0] sync_q, sync_d;

  always_comb begin
    sync_d = {sync_q[0], sddi};
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b00;
    else        sync_q <= sync_d;
  end

  // Sample on the last fclk of the SCK high phase so the synchronizer has settled.
  assign sddi_smp   = sync_q[1];
  assign sample_now = (state_q == SHIFT) && sdclk_q && half_tc;
`else
  assign sddi_smp   = sddi;
  assign sample_now = (state_q == SHIFT) && !sdclk_q && half_tc;
`endif

  assign start_acc = lock_ack_q ? avr_start  : z80_start;
  assign tx_byte   = lock_ack_q ? avr_datain : z80_datain;

  always_comb begin
    state_d    = state_q;
    lock_ack_d = lock_ack_q;
    busy_d     = busy_q;
    sdclk_d    = sdclk_q;
    sddo_d     = sddo_q;
    dataout_d  = dataout_q;
    shift_d    = shift_q;
    in_d       = in_q;
    half_d     = half_q;
    bit_d      = bit_q;

    if (sample_now) in_d = {in_q[6:0], sddi_smp};

    case (state_q)
      IDLE: begin
        lock_ack_d = avr_lock;
        if (start_acc) begin
          shift_d = tx_byte;
          sddo_d  = tx_byte[7];
          busy_d  = 1'b1;
          sdclk_d = 1'b0;
          half_d  = 4'd0;
          bit_d   = 3'd0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (half_tc) begin
          half_d  = 4'd0;
          sdclk_d = ~sdclk_q;
          if (sdclk_q) begin
            if (bit_q == 3'd7) begin
              state_d   = IDLE;
              busy_d    = 1'b0;
              dataout_d = in_d;
              sddo_d    = 1'b1;
              bit_d     = 3'd0;
            end else begin
              shift_d = {shift_q[6:0], 1'b0};
              sddo_d  = shift_q[6];
              bit_d   = bit_q + 3'd1;
            end
          end
        end else begin
          half_d = half_q + 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge fclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      lock_ack_q <= 1'b0;
      busy_q     <= 1'b0;
      sdclk_q    <= 1'b0;
      sddo_q     <= 1'b1;
      dataout_q  <= 8'hFF;
      shift_q    <= 8'h00;
      in_q       <= 8'h00;
      half_q     <= 4'd0;
      bit_q      <= 3'd0;
    end else begin
      state_q    <= state_d;
      lock_ack_q <= lock_ack_d;
      busy_q     <= busy_d;
      sdclk_q    <= sdclk_d;
      sddo_q     <= sddo_d;
      dataout_q  <= dataout_d;
      shift_q    <= shift_d;
      in_q       <= in_d;
      half_q     <= half_d;
      bit_q      <= bit_d;
    end
  end

  assign lock_ack = lock_ack_q;
  assign busy     = busy_q;
  assign dataout  = dataout_q;
  assign sdclk    = sdclk_q;
  assign sddo     = sddo_q;
  assign sdcs_n   = lock_ack_q ? avr_cs_n : z80_cs_n;

endmodule

// File: tb/tb_sdcard_shifter.sv
// Directed bench for sdcard_shifter: SPI slave model on sdclk, MOSI capture on rising SCK.
module tb_sdcard_shifter;
`ifdef SDSHIFT_SYNC_EN
  localparam int HP = 3;
`else
  localparam int HP = 2;
`endif
  localparam int BUSY_LEN = 16 * HP;

  logic       fclk;
  logic       rst_n;
  logic       avr_lock;
  logic       avr_cs_n;
  logic       avr_start;
  logic [7:0] avr_datain;
  logic       z80_cs_n;
  logic       z80_start;
  logic [7:0] z80_datain;
  logic       lock_ack;
  logic       busy;
  logic [7:0] dataout;
  logic       sdclk;
  logic       sddo;
  logic       sddi;
  logic       sdcs_n;

  sdcard_shifter #(.HALF_PER(HP)) dut (
    .fclk(fclk), .rst_n(rst_n),
    .avr_lock(avr_lock), .avr_cs_n(avr_cs_n), .avr_start(avr_start), .avr_datain(avr_datain),
    .z80_cs_n(z80_cs_n), .z80_start(z80_start), .z80_datain(z80_datain),
    .lock_ack(lock_ack), .busy(busy), .dataout(dataout),
    .sdclk(sdclk), .sddo(sddo), .sddi(sddi), .sdcs_n(sdcs_n)
  );

  initial fclk = 1'b0;
  always #5 fclk = ~fclk;

  int errors = 0;
  int checks = 0;

  // Slave model: presents resp MSB first, advances on each falling SCK edge.
  int         neg_cnt = 0;
  int         pos_cnt = 0;
  int         slv_base = 0;
  logic [7:0] slv_resp = 8'hFF;
  logic [7:0] slv_sh;
  logic [7:0] mosi_cap = 8'h00;

  always @(negedge sdclk) neg_cnt++;
  always @(posedge sdclk) begin
    pos_cnt++;
    mosi_cap = {mosi_cap[6:0], sddo};
  end

  always_comb begin
    slv_sh = slv_resp << (neg_cnt - slv_base);
    sddi   = slv_sh[7];
  end

  task automatic xfer(input logic by_avr, input logic both, input logic [7:0] av,
                      input logic [7:0] zv, input logic [7:0] resp,
                      output int bcyc, output int rises);
    int p0;
    @(negedge fclk);
    slv_resp   = resp;
    slv_base   = neg_cnt;
    p0         = pos_cnt;
    avr_datain = av;
    z80_datain = zv;
    avr_start  = by_avr | both;
    z80_start  = ~by_avr | both;
    @(negedge fclk);
    avr_start = 1'b0;
    z80_start = 1'b0;
    bcyc = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      bcyc++;
      @(negedge fclk);
    end
    rises = pos_cnt - p0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; avr_lock = 1'b0; avr_cs_n = 1'b1; avr_start = 1'b0; avr_datain = 8'h00;
    z80_cs_n = 1'b0; z80_start = 1'b0; z80_datain = 8'h00;
    repeat (3) @(negedge fclk);
    rst_n = 1'b1;
    @(negedge fclk);
    checks++; if (sdclk !== 1'b0) begin errors++; $display("FAIL reset_sdclk: got %b expected 0", sdclk); end
    checks++; if (sddo !== 1'b1) begin errors++; $display("FAIL reset_sddo: got %b expected 1", sddo); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (dataout !== 8'hFF) begin errors++; $display("FAIL reset_dataout: got %h expected ff", dataout); end
    checks++; if (lock_ack !== 1'b0) begin errors++; $display("FAIL reset_lock_ack: got %b expected 0", lock_ack); end
    checks++; if (sdcs_n !== 1'b0) begin errors++; $display("FAIL reset_cs_z80_lo: got %b expected 0", sdcs_n); end
    z80_cs_n = 1'b1; avr_cs_n = 1'b0;
    #1;
    checks++; if (sdcs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_z80_hi: got %b expected 1", sdcs_n); end
  endtask

  task automatic test_z80_xfer();
    int bc, rs;
    xfer(1'b0, 1'b0, 8'h00, 8'hA5, 8'h3C, bc, rs);
    checks++; if (dataout !== 8'h3C) begin errors++; $display("FAIL z80_dataout: got %h expected 3c", dataout); end
    checks++; if (mosi_cap !== 8'hA5) begin errors++; $display("FAIL z80_mosi: got %h expected a5", mosi_cap); end
    checks++; if (bc != BUSY_LEN) begin errors++; $display("FAIL z80_busy_len: got %0d expected %0d", bc, BUSY_LEN); end
    checks++; if (rs != 8) begin errors++; $display("FAIL z80_rises: got %0d expected 8", rs); end
    checks++; if (sddo !== 1'b1 || sdclk !== 1'b0) begin errors++; $display("FAIL z80_idle_lines: got sddo=%b sdclk=%b expected 1 0", sddo, sdclk); end
  endtask

  task automatic test_avr_lock();
    int bc, rs;
    @(negedge fclk);
    avr_lock = 1'b1;
    @(negedge fclk);
    checks++; if (lock_ack !== 1'b1) begin errors++; $display("FAIL lock_ack_set: got %b expected 1", lock_ack); end
    avr_cs_n = 1'b0; z80_cs_n = 1'b1;
    #1;
    checks++; if (sdcs_n !== 1'b0) begin errors++; $display("FAIL lock_cs_avr_lo: got %b expected 0", sdcs_n); end
    avr_cs_n = 1'b1; z80_cs_n = 1'b0;
    #1;
    checks++; if (sdcs_n !== 1'b1) begin errors++; $display("FAIL lock_cs_avr_hi: got %b expected 1", sdcs_n); end
    @(negedge fclk);
    z80_start = 1'b1; z80_datain = 8'h12;
    @(negedge fclk);
    z80_start = 1'b0;
    @(negedge fclk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL z80_ignored: got busy=%b expected 0", busy); end
    xfer(1'b1, 1'b0, 8'hFF, 8'h00, 8'h00, bc, rs);
    checks++; if (dataout !== 8'h00) begin errors++; $display("FAIL avr_dataout: got %h expected 00", dataout); end
    checks++; if (mosi_cap !== 8'hFF) begin errors++; $display("FAIL avr_mosi: got %h expected ff", mosi_cap); end
  endtask

  task automatic test_lock_during();
    int   cyc;
    logic moved;
    @(negedge fclk);
    slv_resp = 8'h69; slv_base = neg_cnt;
    avr_datain = 8'h5C; avr_start = 1'b1;
    @(negedge fclk);
    avr_start = 1'b0;
    cyc = 0; moved = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      if (cyc == 5) avr_lock = 1'b0;
      if (lock_ack !== 1'b1) moved = 1'b1;
      cyc++;
      @(negedge fclk);
    end
    checks++; if (moved !== 1'b0) begin errors++; $display("FAIL lock_frozen: got change=%b expected 0", moved); end
    checks++; if (lock_ack !== 1'b1) begin errors++; $display("FAIL lock_at_fall: got %b expected 1", lock_ack); end
    checks++; if (dataout !== 8'h69) begin errors++; $display("FAIL lock_dataout: got %h expected 69", dataout); end
    @(negedge fclk);
    checks++; if (lock_ack !== 1'b0) begin errors++; $display("FAIL lock_after: got %b expected 0", lock_ack); end
  endtask

  task automatic test_back_to_back();
    int bc, p0, rs;
    @(negedge fclk);
    slv_resp = 8'h96; slv_base = neg_cnt; p0 = pos_cnt;
    z80_datain = 8'h5A; z80_start = 1'b1;
    @(negedge fclk);
    z80_start = 1'b0;
    bc = 0;
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      if (bc == 3 || bc == 10) begin
        avr_start = 1'b1; z80_start = 1'b1; avr_datain = 8'hC3; z80_datain = 8'h11;
      end else begin
        avr_start = 1'b0; z80_start = 1'b0;
      end
      bc++;
      @(negedge fclk);
    end
    rs = pos_cnt - p0;
    checks++; if (bc != BUSY_LEN) begin errors++; $display("FAIL b2b_busy_len: got %0d expected %0d", bc, BUSY_LEN); end
    checks++; if (rs != 8) begin errors++; $display("FAIL b2b_rises: got %0d expected 8", rs); end
    checks++; if (mosi_cap !== 8'h5A) begin errors++; $display("FAIL b2b_mosi: got %h expected 5a", mosi_cap); end
    checks++; if (dataout !== 8'h96) begin errors++; $display("FAIL b2b_dataout: got %h expected 96", dataout); end
    slv_resp = 8'hF0; slv_base = neg_cnt;
    z80_datain = 8'h0F; z80_start = 1'b1;
    @(negedge fclk);
    z80_start = 1'b0;
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL b2b_restart: got busy=%b expected 1", busy); end
    for (int i = 0; i < 400; i++) begin
      if (!busy) break;
      @(negedge fclk);
    end
    checks++; if (dataout !== 8'hF0) begin errors++; $display("FAIL b2b2_dataout: got %h expected f0", dataout); end
    checks++; if (mosi_cap !== 8'h0F) begin errors++; $display("FAIL b2b2_mosi: got %h expected 0f", mosi_cap); end
    xfer(1'b0, 1'b1, 8'hC3, 8'h3C, 8'hE1, bc, rs);
    checks++; if (mosi_cap !== 8'h3C) begin errors++; $display("FAIL both_owner_mosi: got %h expected 3c", mosi_cap); end
    checks++; if (rs != 8 || bc != BUSY_LEN) begin errors++; $display("FAIL both_single: got rises=%0d busy=%0d expected 8 %0d", rs, bc, BUSY_LEN); end
    checks++; if (dataout !== 8'hE1) begin errors++; $display("FAIL both_dataout: got %h expected e1", dataout); end
  endtask

  task automatic test_reset_mid();
    int bc, rs, p0;
    @(negedge fclk);
    slv_resp = 8'hAA; slv_base = neg_cnt; p0 = pos_cnt;
    z80_datain = 8'h77; z80_start = 1'b1;
    @(negedge fclk);
    z80_start = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (pos_cnt - p0 >= 3) break;
      @(negedge fclk);
    end
    checks++; if (sdclk !== 1'b1) begin errors++; $display("FAIL mid_sdclk_high: got %b expected 1", sdclk); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (sdclk !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL mid_rst_clk_busy: got sdclk=%b busy=%b expected 0 0", sdclk, busy); end
    checks++; if (dataout !== 8'hFF || sddo !== 1'b1 || lock_ack !== 1'b0) begin errors++; $display("FAIL mid_rst_vals: got dataout=%h sddo=%b lock=%b expected ff 1 0", dataout, sddo, lock_ack); end
    @(negedge fclk);
    rst_n = 1'b1;
    xfer(1'b0, 1'b0, 8'h00, 8'h81, 8'h7E, bc, rs);
    checks++; if (dataout !== 8'h7E) begin errors++; $display("FAIL post_rst_dataout: got %h expected 7e", dataout); end
    checks++; if (mosi_cap !== 8'h81) begin errors++; $display("FAIL post_rst_mosi: got %h expected 81", mosi_cap); end
    checks++; if (bc != BUSY_LEN) begin errors++; $display("FAIL post_rst_busy_len: got %0d expected %0d", bc, BUSY_LEN); end
  endtask

  initial begin
    test_reset();
    test_z80_xfer();
    test_avr_lock();
    test_lock_during();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sdcard_shifter.md
Name: sdcard_shifter

Overview:
- SPI-master byte shifter for the SD card. Sits directly downstream of the AVR SPI slave: consumes its sd_start, sd_datain, sd_cs_n and sd_lock_out, and returns sd_dataout and sd_lock_in.
- Also serves the Z80 SD port, so the AVR and the Z80 share one card.
- Arbitration follows the AVR lock bit. Each start pulse shifts one byte out on SDDO MSB-first and one byte in from SDDI (SPI mode 0).

Parameters:
- HALF_PER, 2: fclk cycles per SCK half-period. Legal range 2..15; 3..15 when SDSHIFT_SYNC_EN is defined.

Ports:
- fclk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- avr_lock  in  1  AVR lock request (from slave sd_lock_out)
- avr_cs_n  in  1  AVR chip-select request
- avr_start  in  1  AVR one-cycle start strobe
- avr_datain  in  8  AVR byte to send
- z80_cs_n  in  1  Z80 chip-select request
- z80_start  in  1  Z80 one-cycle start strobe
- z80_datain  in  8  Z80 byte to send
- lock_ack  out  1  effective owner, 1 = AVR (to slave sd_lock_in)
- busy  out  1  transfer in progress
- dataout  out  8  last received byte (to slave sd_dataout and Z80 read port)
- sdclk  out  1  SD SCK
- sddo  out  1  SD MOSI
- sddi  in  1  SD MISO
- sdcs_n  out  1  SD chip select

Behaviour:
- Reset values: state IDLE, sdclk=0, sddo=1, busy=0, dataout=8'hFF, lock_ack=0, half-period counter=0, bit counter=0.
- lock_ack register:
  - Loads avr_lock on every fclk edge while in IDLE.
  - Frozen while in SHIFT; a lock change during a transfer takes effect on the first IDLE cycle after the transfer ends.
- sdcs_n is combinational: lock_ack ? avr_cs_n : z80_cs_n.
- Start acceptance, in IDLE only:
  - Accepted start = lock_ack ? avr_start : z80_start, evaluated against the lock_ack value present in that cycle.
  - The non-owner's start is ignored, with no queuing.
  - Any start arriving while in SHIFT is ignored.
- On an accepted start (edge N):
  - Latch the owner's byte into shift_reg.
  - sddo <= byte[7], busy <= 1, sdclk stays 0, half counter cleared.
  - State -> SHIFT.
- SHIFT state:
  - The half counter counts 0..HALF_PER-1; on the terminal count sdclk toggles, giving 16 toggles in total.
  - Rising toggle: sample sddi into in_reg LSB (in_reg shifts left).
  - Falling toggle 1..7: shift_reg shifts left; sddo <= next MSB.
  - Falling toggle 8: state -> IDLE, busy <= 0, dataout <= received byte, sddo <= 1.
- Timing:
  - Busy lasts exactly 16*HALF_PER fclk cycles.
  - A new start is accepted in the cycle after busy falls.
  - The first rising SCK edge is HALF_PER cycles after acceptance.
- Async reset mid-transfer: all registers return to reset values immediately and the transfer is abandoned. dataout = FF, sdclk = 0 with no runt high pulse beyond the reset assertion.
- avr_start and z80_start in the same IDLE cycle: only the owner's start is taken.

Optional Feature:
- SDSHIFT_SYNC_EN defined:
  - sddi passes through a 2-flop synchronizer.
  - The sample point moves from the rising toggle to the fclk cycle before the following falling toggle, i.e. half counter = HALF_PER-1 while sdclk = 1.
  - HALF_PER must be >= 3.
- Not defined:
  - sddi is sampled directly on the rising-toggle edge.
- Transfer length and busy duration are identical in both builds.

Test Plan:
- Reset, then IDLE → sdclk=0, sddo=1, busy=0, dataout=FF, lock_ack=0, and sdcs_n follows z80_cs_n.
- Both builds: avr_lock=0, z80_start with 8'hA5, sddi driven from a slave model returning 8'h3C → sddo bits 1,0,1,0,0,1,0,1 on successive rising SCK edges; dataout=3C. With HALF_PER=2, busy is high for exactly 32 cycles.
- avr_lock=1 held for one IDLE cycle → lock_ack=1 and sdcs_n tracks avr_cs_n. z80_start is ignored (busy stays 0). avr_start with 8'hFF and sddi=0 → dataout=00.
- Toggle avr_lock during a transfer → lock_ack unchanged until the cycle after busy falls.
- Start pulses during busy, plus simultaneous avr_start/z80_start in IDLE → exactly one 16-toggle transfer, using the owner's data.
- Assert rst_n mid-transfer after bit 3 → immediate reset values. The next accepted start performs a full, correct 8-bit transfer.
